// File: rtl/find_box_multi_mode.sv
// Motion bounding-box finder: accumulates the box of set pixels in a 1-bit mask stream,
// commits it at mask end-of-frame, and overlays it as a thick rectangle on an RGB565 stream.
module find_box_multi_mode #(
    parameter int          IMG_W     = 640,
    parameter int          IMG_H     = 480,
    parameter int          CNT_W     = 11,
    parameter int          PIX_W     = 20,
    parameter int          THICK     = 4,
    parameter int          MIN_PIX   = 64,
    parameter logic [15:0] BOX_COLOR = 16'hF800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msk_vsync,
    input  logic             msk_href,
    input  logic             msk_clken,
    input  logic             msk_bit,
    input  logic             vid_vsync,
    input  logic             vid_href,
    input  logic             vid_clken,
    input  logic [15:0]      vid_data,
    input  logic [1:0]       mode,
    output logic             post_vsync,
    output logic             post_href,
    output logic             post_clken,
    output logic [15:0]      post_data,
    output logic [CNT_W-1:0] box_left,
    output logic [CNT_W-1:0] box_right,
    output logic [CNT_W-1:0] box_top,
    output logic [CNT_W-1:0] box_bottom,
    output logic             box_valid,
    output logic [PIX_W-1:0] box_pix_cnt,
    output logic             frame_done
);

    typedef enum logic [1:0] {WAIT_LOW, IDLE, ACCUM} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic [CNT_W:0]   TM1     = (CNT_W+1)'(THICK - 1);

    // ---------------- mask stream position counters ----------------
    logic             m_vs_q, m_href_q;
    logic [CNT_W-1:0] m_h_q, m_v_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_vs_q   <= 1'b0;
            m_href_q <= 1'b0;
            m_h_q    <= '0;
            m_v_q    <= '0;
        end else begin
            m_vs_q   <= msk_vsync;
            m_href_q <= msk_href;
            if (!msk_href)
                m_h_q <= '0;
            else if (msk_clken && m_h_q != CNT_MAX)
                m_h_q <= m_h_q + 1'b1;
            if (!msk_vsync)
                m_v_q <= '0;
            else if (m_href_q && !msk_href && m_v_q != CNT_MAX)
                m_v_q <= m_v_q + 1'b1;
        end
    end

    // ---------------- mask FSM and accumulators ----------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] top_q, top_d, bot_q, bot_d, left_q, left_d, right_q, right_d;
    logic [PIX_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] box_left_q, box_left_d, box_right_q, box_right_d;
    logic [CNT_W-1:0] box_top_q, box_top_d, box_bottom_q, box_bottom_d;
    logic [PIX_W-1:0] box_cnt_q, box_cnt_d;
    logic             box_valid_q, box_valid_d, frame_done_q, frame_done_d;

    logic             m_pix, m_rise, m_fall, start, acc_en;
    logic [CNT_W-1:0] b_top, b_bot, b_left, b_right;
    logic [PIX_W-1:0] b_cnt;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        box_left_d   = box_left_q;
        box_right_d  = box_right_q;
        box_top_d    = box_top_q;
        box_bottom_d = box_bottom_q;
        box_cnt_d    = box_cnt_q;
        box_valid_d  = box_valid_q;
        frame_done_d = 1'b0;

        m_pix  = msk_href & msk_clken & msk_bit;
        m_rise = msk_vsync & ~m_vs_q;
        m_fall = ~msk_vsync & m_vs_q;
        start  = (state_q == IDLE) && m_rise;
        acc_en = m_pix && (start || (state_q == ACCUM && msk_vsync));

        // A pixel in the rising-edge cycle is folded into freshly initialised accumulators.
        b_top   = start ? CNT_W'(IMG_H - 1) : top_q;
        b_bot   = start ? '0                : bot_q;
        b_left  = start ? CNT_W'(IMG_W - 1) : left_q;
        b_right = start ? '0                : right_q;
        b_cnt   = start ? '0                : cnt_q;

        top_d   = b_top;
        bot_d   = b_bot;
        left_d  = b_left;
        right_d = b_right;
        cnt_d   = b_cnt;
        if (acc_en) begin
            if (m_v_q < b_top)   top_d   = m_v_q;
            if (m_v_q > b_bot)   bot_d   = m_v_q;
            if (m_h_q < b_left)  left_d  = m_h_q;
            if (m_h_q > b_right) right_d = m_h_q;
            if (b_cnt != PIX_MAX) cnt_d  = b_cnt + 1'b1;
        end

        case (state_q)
            WAIT_LOW: if (!msk_vsync) state_d = IDLE;
            IDLE:     if (start) state_d = ACCUM;
            ACCUM: begin
                if (m_fall) begin
                    state_d      = IDLE;
                    box_left_d   = left_q;
                    box_right_d  = right_q;
                    box_top_d    = top_q;
                    box_bottom_d = bot_q;
                    box_cnt_d    = cnt_q;
                    box_valid_d  = (cnt_q >= PIX_W'(MIN_PIX));
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_LOW;
            top_q        <= '0;
            bot_q        <= '0;
            left_q       <= '0;
            right_q      <= '0;
            cnt_q        <= '0;
            box_left_q   <= '0;
            box_right_q  <= '0;
            box_top_q    <= '0;
            box_bottom_q <= '0;
            box_cnt_q    <= '0;
            box_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            left_q       <= left_d;
            right_q      <= right_d;
            cnt_q        <= cnt_d;
            box_left_q   <= box_left_d;
            box_right_q  <= box_right_d;
            box_top_q    <= box_top_d;
            box_bottom_q <= box_bottom_d;
            box_cnt_q    <= box_cnt_d;
            box_valid_q  <= box_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ---------------- video stream counters and mode ----------------
    logic             v_vs_q, v_href_q;
    logic [CNT_W-1:0] v_h_q, v_v_q;
    logic [1:0]       mode_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_vs_q   <= 1'b0;
            v_href_q <= 1'b0;
            v_h_q    <= '0;
            v_v_q    <= '0;
            mode_q   <= 2'd0;
        end else begin
            v_vs_q   <= vid_vsync;
            v_href_q <= vid_href;
            if (vid_vsync && !v_vs_q)
                mode_q <= mode;
            if (!vid_href)
                v_h_q <= '0;
            else if (vid_clken && v_h_q != CNT_MAX)
                v_h_q <= v_h_q + 1'b1;
            if (!vid_vsync)
                v_v_q <= '0;
            else if (v_href_q && !vid_href && v_v_q != CNT_MAX)
                v_v_q <= v_v_q + 1'b1;
        end
    end

    // ---------------- rectangle hit test and output pixel ----------------
    logic [CNT_W:0] ex, ey, el, er, eu, ed;
    logic           in_vband, in_hband, on_edge;
    logic [15:0]    base_pix, post_data_d;
    logic           post_vsync_q, post_href_q, post_clken_q;
    logic [15:0]    post_data_q;

    // One extra bit keeps R+THICK-1 and D+THICK-1 from wrapping near the counter limit.
    always_comb begin
        ex = {1'b0, v_h_q};
        ey = {1'b0, v_v_q};
        el = {1'b0, box_left_q};
        er = {1'b0, box_right_q};
        eu = {1'b0, box_top_q};
        ed = {1'b0, box_bottom_q};
        in_vband = ((ex >= el && ex <= el + TM1) || (ex >= er && ex <= er + TM1))
                   && ey >= eu && ey <= ed + TM1;
        in_hband = ((ey >= eu && ey <= eu + TM1) || (ey >= ed && ey <= ed + TM1))
                   && ex >= el && ex <= er + TM1;
        on_edge  = in_vband || in_hband;

        base_pix    = mode_q[1] ? {16{msk_bit}} : vid_data;
        post_data_d = 16'h0000;
        if (vid_href && vid_clken)
            post_data_d = (mode_q[0] && box_valid_q && on_edge) ? BOX_COLOR : base_pix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_vsync_q <= 1'b0;
            post_href_q  <= 1'b0;
            post_clken_q <= 1'b0;
            post_data_q  <= '0;
        end else begin
            post_vsync_q <= vid_vsync;
            post_href_q  <= vid_href;
            post_clken_q <= vid_clken;
            post_data_q  <= post_data_d;
        end
    end

    assign post_vsync  = post_vsync_q;
    assign post_href   = post_href_q;
    assign post_clken  = post_clken_q;
    assign post_data   = post_data_q;
    assign box_left    = box_left_q;
    assign box_right   = box_right_q;
    assign box_top     = box_top_q;
    assign box_bottom  = box_bottom_q;
    assign box_valid   = box_valid_q;
    assign box_pix_cnt = box_cnt_q;
    assign frame_done  = frame_done_q;

endmodule
